// File: rtl/uart_frame_loader_pkg.sv
// Shared types and constants for the UART frame loader: FSM states, abort codes, sync marker.
package uart_frame_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_LO,
    ST_RX_HI,
    ST_RX_CSUM,
    ST_WAIT_FFT
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_UART    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // States in which bytes belong to a frame and the inter-byte timer runs.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_RX_LO) || (s == ST_RX_HI) || (s == ST_RX_CSUM);
  endfunction

endpackage

// File: rtl/uart_frame_loader_timer.sv
// Loadable down-counter: clear forces zero, load presets, o_expire flags a count of zero.
module frame_timeout_timer #(
  parameter int W = 17
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // NOTE: state is written with <= only, so every flop samples the pre-edge values of its peers.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/uart_frame_loader.sv
// Frame loader: hunts for the sync byte, writes 16 LE samples to the FFT buffer,
// verifies the additive checksum, launches the FFT and waits for its completion.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int         N_SAMPLES      = 16,
  parameter int         SAMPLE_W       = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 104160
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_rx_valid,
  input  logic [7:0]                   i_rx_byte,
  input  logic                         i_rx_error,
  output logic                         o_wr_en,
  output logic [$clog2(N_SAMPLES)-1:0] o_wr_addr,
  output logic [SAMPLE_W-1:0]          o_wr_data,
  output logic                         o_fft_start,
  input  logic                         i_fft_done,
  output logic                         o_busy,
  output logic                         o_frame_ok,
  output logic                         o_frame_err,
  output logic [1:0]                   o_err_code
);

  localparam int AW = $clog2(N_SAMPLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t              r_state;
  err_code_t           r_err_code;
  logic [AW-1:0]       r_idx;
  logic [7:0]          r_csum;
  logic [7:0]          r_lo;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [SAMPLE_W-1:0] r_wr_data;
  logic                r_fft_start;
  logic                r_busy;
  logic                r_frame_ok;
  logic                r_frame_err;

  logic w_rx_state;
  logic w_sync_hit;
  logic w_tmr_load;
  logic w_tmr_clear;
  logic w_tmr_expire;

  assign w_rx_state  = is_rx_state(r_state);
  assign w_sync_hit  = (r_state == ST_IDLE) && i_rx_valid && (i_rx_byte == SYNC_BYTE);
  // The timer restarts on frame entry and on every byte that is actually accepted.
  assign w_tmr_load  = w_sync_hit || (w_rx_state && i_rx_valid && !i_rx_error);
  assign w_tmr_clear = !w_rx_state && !w_tmr_load;

  frame_timeout_timer #(
    .W (TW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_tmr_clear),
    .i_load     (w_tmr_load),
    .i_load_val (TW'(TIMEOUT_CYCLES - 1)),
    .i_en       (w_rx_state),
    .o_expire   (w_tmr_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_err_code  <= ERR_NONE;
      r_idx       <= '0;
      r_csum      <= '0;
      r_lo        <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_fft_start <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_fft_start <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_sync_hit) begin
            r_state <= ST_RX_LO;
            r_idx   <= '0;
            r_csum  <= '0;
            r_busy  <= 1'b1;
          end
        end

        ST_RX_LO, ST_RX_HI, ST_RX_CSUM: begin
          if (i_rx_error) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_UART;
          end else if (i_rx_valid) begin
            if (r_state == ST_RX_LO) begin
              r_lo    <= i_rx_byte;
              r_csum  <= r_csum + i_rx_byte;
              r_state <= ST_RX_HI;
            end else if (r_state == ST_RX_HI) begin
              r_csum    <= r_csum + i_rx_byte;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_idx;
              r_wr_data <= {i_rx_byte, r_lo};
              if (r_idx == AW'(N_SAMPLES - 1)) begin
                r_state <= ST_RX_CSUM;
              end else begin
                r_idx   <= r_idx + AW'(1);
                r_state <= ST_RX_LO;
              end
            end else if (i_rx_byte == r_csum) begin
              r_fft_start <= 1'b1;
              r_frame_ok  <= 1'b1;
              r_state     <= ST_WAIT_FFT;
            end else begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_CSUM;
            end
          end else if (w_tmr_expire) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
          end
        end

        ST_WAIT_FFT: begin
          if (i_fft_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        // NOTE: unused encodings fall back to IDLE so a corrupted state register self-recovers.
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_fft_start = r_fft_start;
  assign o_busy      = r_busy;
  assign o_frame_ok  = r_frame_ok;
  assign o_frame_err = r_frame_err;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench: byte-position reference model compared every cycle, plus directed literal checks.
module tb_uart_frame_loader;

  localparam int         N  = 16;
  localparam int         TO = 64;
  localparam logic [7:0] SB = 8'hA5;

  logic        clk;
  logic        i_rst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_byte;
  logic        i_rx_error;
  logic        o_wr_en;
  logic [3:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_fft_start;
  logic        i_fft_done;
  logic        o_busy;
  logic        o_frame_ok;
  logic        o_frame_err;
  logic [1:0]  o_err_code;

  uart_frame_loader #(
    .N_SAMPLES      (N),
    .SAMPLE_W       (16),
    .SYNC_BYTE      (SB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx_valid  (i_rx_valid),
    .i_rx_byte   (i_rx_byte),
    .i_rx_error  (i_rx_error),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_fft_start (o_fft_start),
    .i_fft_done  (i_fft_done),
    .o_busy      (o_busy),
    .o_frame_ok  (o_frame_ok),
    .o_frame_err (o_frame_err),
    .o_err_code  (o_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the frame as a byte count and a payload array.
  typedef enum {M_IDLE, M_RECV, M_WAIT} mode_t;
  mode_t       m_mode;
  int          m_nbytes;
  int          m_cyc = 0;
  int          m_last;
  logic [7:0]  m_payload [2*N];
  logic        model_ready = 1'b0;
  logic        addr_known;
  logic        exp_wr_en, exp_start, exp_ok, exp_err, exp_busy;
  logic [3:0]  exp_addr;
  logic [15:0] exp_data;
  logic [1:0]  exp_code;

  task automatic m_abort(input logic [1:0] code);
    exp_err  = 1'b1;
    exp_code = code;
    exp_busy = 1'b0;
    m_mode   = M_IDLE;
  endtask

  always @(posedge clk) begin
    logic [7:0] sum;
    m_cyc++;
    exp_wr_en = 1'b0;
    exp_start = 1'b0;
    exp_ok    = 1'b0;
    exp_err   = 1'b0;
    if (i_rst) begin
      m_mode      = M_IDLE;
      exp_code    = 2'd0;
      exp_busy    = 1'b0;
      exp_addr    = '0;
      exp_data    = '0;
      addr_known  = 1'b1;
      model_ready = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (i_rx_valid && i_rx_byte == SB) begin
          m_mode   = M_RECV;
          m_nbytes = 0;
          m_last   = m_cyc;
          exp_busy = 1'b1;
        end
        M_WAIT: if (i_fft_done) begin
          m_mode   = M_IDLE;
          exp_busy = 1'b0;
        end
        default: begin
          if (i_rx_error) begin
            m_abort(2'd2);
          end else if (i_rx_valid) begin
            m_last = m_cyc;
            if (m_nbytes < 2*N) begin
              m_payload[m_nbytes] = i_rx_byte;
              m_nbytes++;
              if (m_nbytes % 2 == 0) begin
                exp_wr_en  = 1'b1;
                exp_addr   = 4'(m_nbytes/2 - 1);
                exp_data   = {m_payload[m_nbytes-1], m_payload[m_nbytes-2]};
                addr_known = 1'b1;
              end
            end else begin
              sum = 8'h00;
              for (int i = 0; i < 2*N; i++) sum = sum + m_payload[i];
              if (i_rx_byte == sum) begin
                exp_start = 1'b1;
                exp_ok    = 1'b1;
                m_mode    = M_WAIT;
              end else begin
                m_abort(2'd1);
              end
            end
          end else if (m_cyc - m_last == TO) begin
            m_abort(2'd3);
          end
        end
      endcase
    end
  end

  // Compare process plus observed-event counters for the directed literal checks.
  int          dut_wr_cnt = 0, dut_ok_cnt = 0, dut_start_cnt = 0, dut_err_cnt = 0;
  logic [15:0] dut_mem [N];

  always @(negedge clk) begin
    if (model_ready) begin
      check("busy", o_busy, exp_busy);
      check("wr_en", o_wr_en, exp_wr_en);
      check("fft_start", o_fft_start, exp_start);
      check("frame_ok", o_frame_ok, exp_ok);
      check("frame_err", o_frame_err, exp_err);
      check("err_code", o_err_code, exp_code);
      if (exp_wr_en || addr_known) begin
        check("wr_addr", o_wr_addr, exp_addr);
        check("wr_data", o_wr_data, exp_data);
      end
      if (!exp_wr_en && !i_rst) addr_known = 1'b0;
    end
    if (o_wr_en) begin
      dut_wr_cnt++;
      dut_mem[o_wr_addr] = o_wr_data;
    end
    if (o_frame_ok)  dut_ok_cnt++;
    if (o_fft_start) dut_start_cnt++;
    if (o_frame_err) dut_err_cnt++;
  end

  // Stimulus helpers: each task starts and ends 1 time unit after a rising edge.
  logic rand_done_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      i_rx_valid = 1'b0;
      i_rx_byte  = 8'($urandom);
      i_fft_done = rand_done_en && ($urandom_range(0, 31) == 0);
      tick();
    end
    i_fft_done = 1'b0;
  endtask

  task automatic gap(input int maxgap);
    idle(int'($urandom_range(0, maxgap)));
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    tick();
    i_rx_valid = 1'b0;
    i_rx_byte  = 8'($urandom);
  endtask

  task automatic pulse_err(input logic with_valid);
    i_rx_error = 1'b1;
    i_rx_valid = with_valid;
    i_rx_byte  = 8'($urandom);
    tick();
    i_rx_error = 1'b0;
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
  endtask

  function automatic logic [7:0] frame_csum(input logic [15:0] s [N]);
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < N; i++) sum = sum + s[i][7:0] + s[i][15:8];
    return sum;
  endfunction

  // Sends sync, payload bytes up to count nbytes (LSB first), then the checksum if the payload is complete.
  task automatic send_frame(input logic [15:0] s [N], input logic [7:0] csum, input int maxgap,
                            input int nbytes, input int stall_at, input int stall_len);
    send_byte(SB);
    gap(maxgap);
    for (int i = 0; i < nbytes; i++) begin
      send_byte((i % 2 == 1) ? s[i/2][15:8] : s[i/2][7:0]);
      if (i == stall_at) idle(stall_len);
      else gap(maxgap);
    end
    if (nbytes == 2*N) send_byte(csum);
  endtask

  logic [15:0] ramp [N];
  logic [15:0] rnd  [N];
  int w0, ok0, st0, er0;

  task automatic snap();
    w0  = dut_wr_cnt;
    ok0 = dut_ok_cnt;
    st0 = dut_start_cnt;
    er0 = dut_err_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_byte = 8'h00; i_rx_error = 1'b0; i_fft_done = 1'b0;
    for (int i = 0; i < N; i++) ramp[i] = 16'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", o_busy, 1'b0);
    check("reset_err_code", o_err_code, 2'd0);
    check("reset_wr_data", o_wr_data, 16'h0000);
    i_rst = 1'b0;
    idle(2);
    check("pin_csum_ramp", frame_csum(ramp), 8'h88);

    // Valid ramp frame, back-to-back bytes; stray bytes/errors while waiting on the FFT.
    snap();
    send_frame(ramp, 8'h88, 0, 2*N, -1, 0);
    idle(2);
    check("t1_writes", dut_wr_cnt - w0, 16);
    check("t1_ok", dut_ok_cnt - ok0, 1);
    check("t1_start", dut_start_cnt - st0, 1);
    check("t1_mem0", dut_mem[0], 16'h0001);
    check("t1_mem15", dut_mem[15], 16'h0010);
    check("t1_busy_wait", o_busy, 1'b1);
    snap();
    send_byte(SB); send_byte(8'h01); pulse_err(1'b0); send_byte(SB); idle(3);
    check("t1_wait_ignored", dut_wr_cnt - w0, 0);
    check("t1_still_busy", o_busy, 1'b1);
    pulse_done();
    idle(1);
    check("t1_busy_after_done", o_busy, 1'b0);

    // Bad checksum.
    snap();
    send_frame(ramp, 8'h89, 1, 2*N, -1, 0);
    idle(2);
    check("t2_writes", dut_wr_cnt - w0, 16);
    check("t2_err", dut_err_cnt - er0, 1);
    check("t2_start", dut_start_cnt - st0, 0);
    check("t2_code", o_err_code, 2'd1);
    check("t2_busy", o_busy, 1'b0);

    // Noise then a good frame.
    snap();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A); idle(2);
    check("t3_noise_writes", dut_wr_cnt - w0, 0);
    send_frame(ramp, 8'h88, 2, 2*N, -1, 0);
    idle(2);
    check("t3_ok", dut_ok_cnt - ok0, 1);
    pulse_done();

    // UART error after the 7th payload byte, then a good frame.
    snap();
    send_frame(ramp, 8'h00, 1, 7, -1, 0);
    pulse_err(1'b0);
    idle(2);
    check("t4_code", o_err_code, 2'd2);
    check("t4_writes", dut_wr_cnt - w0, 3);
    snap();
    send_frame(ramp, 8'h88, 1, 2*N, -1, 0);
    idle(2);
    check("t4_next_ok", dut_ok_cnt - ok0, 1);
    pulse_done();

    // Error and valid in the same cycle: error wins, byte dropped.
    snap();
    send_frame(ramp, 8'h00, 0, 3, -1, 0);
    pulse_err(1'b1);
    idle(2);
    check("t5_simul_writes", dut_wr_cnt - w0, 1);
    check("t5_simul_err", dut_err_cnt - er0, 1);

    // Timeout: stall of TO cycles aborts, stall of TO-2 does not.
    snap();
    send_frame(ramp, 8'h00, 0, 4, 3, TO);
    idle(2);
    check("t6_code", o_err_code, 2'd3);
    check("t6_err", dut_err_cnt - er0, 1);
    snap();
    send_frame(ramp, 8'h88, 0, 2*N, 3, TO - 2);
    idle(2);
    check("t6_short_stall_ok", dut_ok_cnt - ok0, 1);
    check("t6_short_stall_err", dut_err_cnt - er0, 0);
    pulse_done();

    // Reset mid-frame: silent discard.
    snap();
    send_frame(ramp, 8'h00, 0, 5, -1, 0);
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    idle(2);
    check("t7_no_err", dut_err_cnt - er0, 0);
    check("t7_busy", o_busy, 1'b0);
    check("t7_code", o_err_code, 2'd0);

    // Randomized frames with noise, faults and stray FFT-done pulses.
    rand_done_en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      int fault;
      int nb;
      for (int i = 0; i < N; i++) rnd[i] = 16'($urandom);
      if (f == 0) rnd[0] = 16'hA5A5;
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] nz;
        nz = 8'($urandom);
        if (nz == SB) nz = 8'h00;
        send_byte(nz);
      end
      fault = int'($urandom_range(0, 5));
      if (fault == 0) begin
        send_frame(rnd, frame_csum(rnd) ^ 8'h01, 2, 2*N, -1, 0);
      end else if (fault == 1) begin
        nb = int'($urandom_range(0, 2*N));
        send_frame(rnd, 8'h00, 2, nb, -1, 0);
        pulse_err(1'($urandom_range(0, 1)));
      end else begin
        send_frame(rnd, frame_csum(rnd), 2, 2*N, -1, 0);
        repeat ($urandom_range(0, 4)) send_byte(8'($urandom));
        pulse_done();
      end
      idle(int'($urandom_range(1, 4)));
    end
    rand_done_en = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
